// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared state encoding and default parameters for run_sequencer.
package run_seq_pkg;

  localparam int unsigned DW            = 8;
  localparam int unsigned DEF_AW        = 8;
  localparam int unsigned DEF_LOAD_BASE = 0;
  localparam int unsigned DEF_LOAD_LEN  = 64;
  localparam int unsigned DEF_OUT_BASE  = 64;
  localparam int unsigned DEF_OUT_LEN   = 32;
  localparam int unsigned DEF_TIMEOUT   = 4095;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4
  } run_state_t;

  // Width of a beat index that can hold every value 0..2^aw inclusive.
  function automatic int unsigned idx_width(input int unsigned aw);
    return $clog2((32'd1 << aw) + 32'd1);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: clearable beat index with a runtime terminal-count compare,
// shared by the load and unload phases.
module beat_counter
  import run_seq_pkg::*;
#(
  parameter int unsigned IW = idx_width(DEF_AW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic [IW-1:0] term,
  output logic [IW-1:0] count,
  output logic          last_c
);

  // Index register: clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + IW'(1);
    end
  end

  assign last_c = (count == term);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: streams an image into data memory, launches the core, waits
// for done under a watchdog, then streams the result window back out.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned LOAD_BASE = DEF_LOAD_BASE,
  parameter int unsigned LOAD_LEN  = DEF_LOAD_LEN,
  parameter int unsigned OUT_BASE  = DEF_OUT_BASE,
  parameter int unsigned OUT_LEN   = DEF_OUT_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_dat,
  input  logic [DW-1:0] mem_rd_dat,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          fin,
  output logic          timeout_err
);

  localparam int unsigned IW = idx_width(AW);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] OUT_BASE_A  = AW'(OUT_BASE);
  localparam logic [IW-1:0] LOAD_TERM   = IW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] OUT_TERM    = IW'(OUT_LEN - 1);
  localparam logic [CW-1:0] WD_LAST     = CW'(TIMEOUT - 1);

  run_state_t    state;
  logic [CW-1:0] wd_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_term;
  logic          idx_clr;
  logic          idx_inc;
  logic          idx_last;

  // s_ready and m_valid are exact registered flags for LOAD and UNLOAD, so
  // they double as phase selects for the beat counter and the memory port.
  assign idx_inc  = (s_ready & s_valid) | (m_valid & m_ready);
  assign idx_clr  = ~(s_ready | m_valid);
  assign idx_term = s_ready ? LOAD_TERM : OUT_TERM;

  beat_counter #(
    .IW(IW)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clr    (idx_clr),
    .inc    (idx_inc),
    .term   (idx_term),
    .count  (idx),
    .last_c (idx_last)
  );

  // Memory port: writes land on the accepting beat; reads are combinational.
  assign mem_wr_en  = s_ready & s_valid;
  assign mem_wr_dat = s_ready ? s_data : '0;
  assign m_data     = m_valid ? mem_rd_dat : '0;

  // Address mux: wraps mod 2^AW, zero outside LOAD/UNLOAD.
  always_comb begin
    mem_addr = '0;
    if (s_ready) begin
      mem_addr = LOAD_BASE_A + AW'(idx);
    end else if (m_valid) begin
      mem_addr = OUT_BASE_A + AW'(idx);
    end
  end

  // Sequencer FSM with registered handshake/status outputs and inline watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      core_req    <= 1'b0;
      busy        <= 1'b0;
      fin         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      core_req <= 1'b0;
      fin      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            s_ready     <= 1'b1;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid && idx_last) begin
            state    <= LAUNCH;
            s_ready  <= 1'b0;
            core_req <= 1'b1;
          end
        end
        LAUNCH: begin
          state  <= RUN;
          wd_cnt <= '0;
        end
        RUN: begin
          if (core_done) begin
            state   <= UNLOAD;
            m_valid <= 1'b1;
          end else if (wd_cnt == WD_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            fin         <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        UNLOAD: begin
          if (m_ready && idx_last) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
            fin     <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized directed sequences against a byte-array model
// of data memory and the sequencer's cycle-level protocol.
module tb_run_sequencer;

  localparam int unsigned AW        = 8;
  localparam int unsigned LOAD_BASE = 0;
  localparam int unsigned LOAD_LEN  = 64;
  localparam int unsigned OUT_BASE  = 64;
  localparam int unsigned OUT_LEN   = 32;
  localparam int unsigned TIMEOUT   = 20;
  localparam int          BUDGET    = 2000;
  localparam int          MSIZE     = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_dat;
  logic [7:0]    mem_rd_dat;
  logic          core_req;
  logic          core_done = 1'b0;
  logic          busy;
  logic          fin;
  logic          timeout_err;

  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_dat = 8'h00;

  logic [7:0]    mem [MSIZE];
  logic [7:0]    ref_mem [MSIZE];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .AW        (AW),
    .LOAD_BASE (LOAD_BASE),
    .LOAD_LEN  (LOAD_LEN),
    .OUT_BASE  (OUT_BASE),
    .OUT_LEN   (OUT_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_dat  (mem_wr_dat),
    .mem_rd_dat  (mem_rd_dat),
    .core_req    (core_req),
    .core_done   (core_done),
    .busy        (busy),
    .fin         (fin),
    .timeout_err (timeout_err)
  );

  // Data memory: bench preload port plus the sequencer's write port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_dat;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;
  end

  assign mem_rd_dat = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"},     32'(s_ready),     0);
    chk({tag, "_m_valid"},     32'(m_valid),     0);
    chk({tag, "_m_data"},      32'(m_data),      0);
    chk({tag, "_mem_wr_en"},   32'(mem_wr_en),   0);
    chk({tag, "_mem_addr"},    32'(mem_addr),    0);
    chk({tag, "_mem_wr_dat"},  32'(mem_wr_dat),  0);
    chk({tag, "_core_req"},    32'(core_req),    0);
    chk({tag, "_busy"},        32'(busy),        0);
    chk({tag, "_fin"},         32'(fin),         0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // One complete sequence. done_dly<0 means done never rises; v_pct<0 means
  // s_valid alternates 0,1,0,1. abort_at>=0 pulls reset during that unload beat.
  task automatic run_seq(input bit skip_start, input int v_pct, input bit addr_data,
                         input int done_dly, input int r_pct, input bit start_at_fin,
                         input int abort_at);
    int            k;
    int            cyc;
    int            nbad;
    int            run_len;
    bit            to;
    int            a;
    logic [7:0]    exp_out [$];

    to      = (done_dly < 0) || (done_dly > int'(TIMEOUT));
    run_len = to ? int'(TIMEOUT) : done_dly;

    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
      #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_s_ready", 32'(s_ready), 0);
      chk("idle_mem_addr", 32'(mem_addr), 0);
    end

    // Load phase: every accepted beat writes the next address.
    k = 0;
    cyc = 0;
    while (k < int'(LOAD_LEN) && cyc < BUDGET) begin
      @(negedge clk);
      start   = 1'($urandom_range(1));
      s_valid = (v_pct < 0) ? ((cyc % 2) == 1) : (int'($urandom_range(99)) < v_pct);
      a       = (int'(LOAD_BASE) + k) % MSIZE;
      s_data  = addr_data ? 8'(a) : 8'($urandom);
      #1;
      chk("load_s_ready", 32'(s_ready), 1);
      chk("load_busy", 32'(busy), 1);
      chk("load_timeout_err", 32'(timeout_err), 0);
      chk("load_core_req", 32'(core_req), 0);
      chk("load_mem_wr_en", 32'(mem_wr_en), 32'(s_valid));
      chk("load_mem_addr", 32'(mem_addr), 32'(a));
      if (s_valid) begin
        chk("load_mem_wr_dat", 32'(mem_wr_dat), 32'(s_data));
        ref_mem[a] = s_data;
        k++;
      end
      cyc++;
    end
    chk("load_beats", 32'(k), LOAD_LEN);

    // Launch: exactly one cycle after the last beat.
    @(negedge clk);
    start   = 1'($urandom_range(1));
    s_valid = 1'($urandom_range(1));
    #1;
    chk("launch_core_req", 32'(core_req), 1);
    chk("launch_s_ready", 32'(s_ready), 0);
    chk("launch_mem_wr_en", 32'(mem_wr_en), 0);
    chk("launch_busy", 32'(busy), 1);
    chk("launch_mem_addr", 32'(mem_addr), 0);
    nbad = 0;
    for (int i = 0; i < MSIZE; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", 32'(nbad), 0);

    // Run: done rises in RUN cycle done_dly, else the watchdog fires.
    for (int j = 1; j <= run_len; j++) begin
      @(negedge clk);
      start     = 1'($urandom_range(1));
      s_valid   = 1'($urandom_range(1));
      core_done = !to && (j == done_dly);
      #1;
      chk("run_core_req", 32'(core_req), 0);
      chk("run_m_valid", 32'(m_valid), 0);
      chk("run_fin", 32'(fin), 0);
      chk("run_busy", 32'(busy), 1);
      chk("run_mem_wr_en", 32'(mem_wr_en), 0);
      chk("run_mem_addr", 32'(mem_addr), 0);
    end

    if (to) begin
      @(negedge clk);
      start     = start_at_fin;
      core_done = 1'b0;
      s_valid   = 1'b0;
      #1;
      chk("wd_fin", 32'(fin), 1);
      chk("wd_timeout_err", 32'(timeout_err), 1);
      chk("wd_busy", 32'(busy), 0);
      chk("wd_m_valid", 32'(m_valid), 0);
      if (!start_at_fin) begin
        @(negedge clk);
        #1;
        chk("wd_fin_pulse", 32'(fin), 0);
        chk("wd_err_sticky", 32'(timeout_err), 1);
        chk("wd_idle_busy", 32'(busy), 0);
      end
      return;
    end

    // Unload: expected bytes are the model's view of the output window.
    for (int i = 0; i < int'(OUT_LEN); i++)
      exp_out.push_back(ref_mem[(int'(OUT_BASE) + i) % MSIZE]);
    k = 0;
    cyc = 0;
    while (k < int'(OUT_LEN) && cyc < BUDGET) begin
      @(negedge clk);
      core_done = 1'b0;
      start     = 1'($urandom_range(1));
      s_valid   = 1'($urandom_range(1));
      m_ready   = int'($urandom_range(99)) < r_pct;
      #1;
      chk("unl_m_valid", 32'(m_valid), 1);
      chk("unl_mem_addr", 32'(mem_addr), 32'((int'(OUT_BASE) + k) % MSIZE));
      chk("unl_m_data", 32'(m_data), 32'(exp_out[k]));
      chk("unl_fin", 32'(fin), 0);
      chk("unl_busy", 32'(busy), 1);
      chk("unl_mem_wr_en", 32'(mem_wr_en), 0);
      chk("unl_s_ready", 32'(s_ready), 0);
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        s_valid = 1'b0;
        return;
      end
      if (m_ready) k++;
      cyc++;
    end
    chk("unl_beats", 32'(k), OUT_LEN);

    @(negedge clk);
    start   = start_at_fin;
    m_ready = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("done_fin", 32'(fin), 1);
    chk("done_m_valid", 32'(m_valid), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_timeout_err", 32'(timeout_err), 0);
    chk("done_mem_addr", 32'(mem_addr), 0);
    if (!start_at_fin) begin
      @(negedge clk);
      #1;
      chk("done_fin_pulse", 32'(fin), 0);
      chk("done_idle_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    logic [7:0] d;
    #1 reset = 1'b0;

    // Preload memory (and the model) while reset is held.
    for (int i = 0; i < MSIZE; i++) begin
      if (i >= int'(OUT_BASE) && i < int'(OUT_BASE + OUT_LEN)) d = 8'(8'hA0 + i - int'(OUT_BASE));
      else d = 8'($urandom);
      ref_mem[i] = d;
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = AW'(i);
      pre_dat  = d;
    end
    @(negedge clk);
    pre_en = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("post_reset");

    run_seq(0, 100, 1, 10, 100, 0, -1);               // basic load, data = address
    run_seq(0, -1, 0, 5, 40, 0, -1);                  // alternating s_valid, back-pressure
    run_seq(0, 70, 0, int'(TIMEOUT), 60, 0, -1);      // done on final watchdog cycle wins
    run_seq(0, 100, 0, -1, 100, 1, -1);               // watchdog, restart in fin cycle
    run_seq(1, 80, 0, 3, 100, 0, -1);                 // chained run clears the error
    run_seq(0, 90, 0, int'(TIMEOUT) + 1, 100, 0, -1); // done one cycle too late
    run_seq(0, 100, 0, 4, 50, 0, 10);                 // reset during unload
    run_seq(0, 100, 1, 7, 100, 0, -1);                // full sequence after reset
    for (int r = 0; r < 4; r++)
      run_seq(0, int'($urandom_range(30, 100)), 0, int'($urandom_range(1, TIMEOUT + 2)),
              int'($urandom_range(20, 100)), 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
